// File: rtl/parity_pkg.sv
// parity_pkg
// Shared constants for the parity frame arbiter: FSM state encoding,
// default frame geometry and the requester-ID width.
package parity_pkg;

   localparam int DATA_W_DEF    = 4;
   localparam int FRAME_LEN_DEF = 4;
   localparam int ID_W          = 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCUM  = 2'd1;
   localparam logic [1:0] ST_RESULT = 2'd2;

   function automatic logic [1:0] id_onehot(input logic [ID_W-1:0] id);
      return (id == 1'b1) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/parity_accum.sv
// parity_accum
// Running XOR of every bit of the current frame plus the word counter.
//   clk_sys  in   clock
//   rst_b    in   async active-low reset
//   clear    in   zero acc and cnt (wins over enable)
//   enable   in   fold word into acc and advance cnt
//   word     in   frame word
//   acc      out  parity of all words accepted so far
//   last     out  cnt == FRAME_LEN-1, i.e. the next accepted word ends the frame
module parity_accum #(
   parameter int DATA_W    = 4,
   parameter int FRAME_LEN = 4,
   parameter int CNT_W     = 4
) (
   input  logic              clk_sys,
   input  logic              rst_b,
   input  logic              clear,
   input  logic              enable,
   input  logic [DATA_W-1:0] word,
   output logic              acc,
   output logic              last
);

   logic [CNT_W-1:0] cnt;

   assign last = (cnt == CNT_W'(FRAME_LEN - 1));

   // cnt parks on FRAME_LEN-1 after the final word so it can never wrap,
   // even when FRAME_LEN == 2**CNT_W.
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         acc <= 1'b0;
         cnt <= '0;
      end else if (clear) begin
         acc <= 1'b0;
         cnt <= '0;
      end else if (enable) begin
         acc <= acc ^ (^word);
         if (!last) cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/parity_frame_arbiter.sv
// parity_frame_arbiter
// Round-robin share of one parity engine between two frame requesters.
//   CLOCK_50     in   clock
//   RESET_N      in   async active-low reset
//   req[1:0]     in   frame request per requester, held for the whole frame
//   in_valid     in   word valid per requester
//   in_data0/1   in   requester words
//   cfg_odd      in   0 even / 1 odd parity, captured at grant
//   in_ready     out  word accept, only toward the granted requester in ACCUM
//   gnt          out  registered one-hot grant
//   busy         out  not IDLE
//   res_valid    out  one-cycle result pulse
//   res_parity   out  result, held between pulses
//   res_id       out  owner of res_parity
//   frame_abort  out  one-cycle pulse when the owner drops req mid-frame
//
// state     | meaning
// ST_IDLE   | no frame; arbitrate among asserted req
// ST_ACCUM  | granted requester streaming words
// ST_RESULT | one cycle presenting res_valid, then back to IDLE
module parity_frame_arbiter
   import parity_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int FRAME_LEN = FRAME_LEN_DEF,
   parameter int CNT_W     = 4
) (
   input  logic              CLOCK_50,
   input  logic              RESET_N,
   input  logic [1:0]        req,
   input  logic [1:0]        in_valid,
   input  logic [DATA_W-1:0] in_data0,
   input  logic [DATA_W-1:0] in_data1,
   input  logic              cfg_odd,
   output logic [1:0]        in_ready,
   output logic [1:0]        gnt,
   output logic              busy,
   output logic              res_valid,
   output logic              res_parity,
   output logic              res_id,
   output logic              frame_abort
);

   logic [1:0]        state;
   logic [ID_W-1:0]   own_id;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   arb_win;
   logic              odd_lat;
   logic              acc;
   logic              last;
   logic              start;
   logic              xfer;
   logic              abort;
   logic [DATA_W-1:0] word;

   assign busy     = (state != ST_IDLE);
   assign in_ready = (state == ST_ACCUM) ? gnt : 2'b00;
   assign word     = (own_id == 1'b1) ? in_data1 : in_data0;
   assign start    = (state == ST_IDLE) && (req != 2'b00);
   assign xfer     = (state == ST_ACCUM) && in_valid[own_id];
   assign abort    = (state == ST_ACCUM) && !req[own_id];
   // Single request wins outright; a tie goes to the round-robin pointer.
   assign arb_win  = (req == 2'b11) ? rr_ptr : req[1];

   parity_accum #(
      .DATA_W    (DATA_W),
      .FRAME_LEN (FRAME_LEN),
      .CNT_W     (CNT_W)
   ) u_accum (
      .clk_sys (CLOCK_50),
      .rst_b   (RESET_N),
      .clear   (start | abort),
      .enable  (xfer & ~abort),
      .word    (word),
      .acc     (acc),
      .last    (last)
   );

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state       <= ST_IDLE;
         gnt         <= 2'b00;
         own_id      <= '0;
         rr_ptr      <= '0;
         odd_lat     <= 1'b0;
         res_valid   <= 1'b0;
         res_parity  <= 1'b0;
         res_id      <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         res_valid   <= 1'b0;
         frame_abort <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  gnt     <= id_onehot(arb_win);
                  own_id  <= arb_win;
                  odd_lat <= cfg_odd;
                  state   <= ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (abort) begin
                  frame_abort <= 1'b1;
                  rr_ptr      <= ~own_id;
                  gnt         <= 2'b00;
                  state       <= ST_IDLE;
               end else if (xfer && last) begin
                  // Fold the final word in here so the result lands in the
                  // same cycle as res_valid.
                  res_valid  <= 1'b1;
                  res_parity <= acc ^ (^word) ^ odd_lat;
                  res_id     <= own_id;
                  state      <= ST_RESULT;
               end
            end
            ST_RESULT: begin
               rr_ptr <= ~own_id;
               gnt    <= 2'b00;
               state  <= ST_IDLE;
            end
            default: begin
               gnt   <= 2'b00;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_parity_frame_arbiter.sv
// tb_parity_frame_arbiter
// Directed bench. Outputs are packed as
// {gnt[1:0], in_ready[1:0], busy, res_valid, res_parity, res_id, frame_abort}
// and compared #1 after each rising edge against hand-computed vectors.
module tb_parity_frame_arbiter;

   logic       clk;
   logic       rst_n;
   logic [1:0] req;
   logic [1:0] in_valid;
   logic [3:0] in_data0;
   logic [3:0] in_data1;
   logic       cfg_odd;
   logic [1:0] in_ready;
   logic [1:0] gnt;
   logic       busy;
   logic       res_valid;
   logic       res_parity;
   logic       res_id;
   logic       frame_abort;

   int n_assert = 0;
   int n_fail   = 0;

   parity_frame_arbiter #(.DATA_W(4), .FRAME_LEN(4), .CNT_W(4)) dut (
      .CLOCK_50    (clk),
      .RESET_N     (rst_n),
      .req         (req),
      .in_valid    (in_valid),
      .in_data0    (in_data0),
      .in_data1    (in_data1),
      .cfg_odd     (cfg_odd),
      .in_ready    (in_ready),
      .gnt         (gnt),
      .busy        (busy),
      .res_valid   (res_valid),
      .res_parity  (res_parity),
      .res_id      (res_id),
      .frame_abort (frame_abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [8:0] outs();
      return {gnt, in_ready, busy, res_valid, res_parity, res_id, frame_abort};
   endfunction

   function automatic logic [8:0] pk(input logic [1:0] g, input logic [1:0] r,
                                     input logic b, input logic rv, input logic rp,
                                     input logic rid, input logic ab);
      return {g, r, b, rv, rp, rid, ab};
   endfunction

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int id, input logic [3:0] d);
      in_valid[id] = 1'b1;
      if (id == 0) in_data0 = d;
      else         in_data1 = d;
      tick();
      in_valid[id] = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; req = 2'b00; in_valid = 2'b00;
      in_data0 = 4'h0; in_data1 = 4'h0; cfg_odd = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset", outs(), pk(2'b00, 2'b00, 0, 0, 0, 0, 0));
      rst_n = 1'b1;

      // Even parity frame 1,2,4,8 from requester 0
      req = 2'b01;
      tick();
      chk("t1_grant", outs(), pk(2'b01, 2'b01, 1, 0, 0, 0, 0));
      send(0, 4'h1); send(0, 4'h2); send(0, 4'h4);
      chk("t1_mid", outs(), pk(2'b01, 2'b01, 1, 0, 0, 0, 0));
      send(0, 4'h8);
      chk("t1_result", outs(), pk(2'b01, 2'b00, 1, 1, 0, 0, 0));
      tick();
      chk("t1_idle", outs(), pk(2'b00, 2'b00, 0, 0, 0, 0, 0));

      // Same words, odd parity latched at grant; cfg_odd flipped mid-frame
      cfg_odd = 1'b1;
      tick();
      chk("t1b_grant", outs(), pk(2'b01, 2'b01, 1, 0, 0, 0, 0));
      cfg_odd = 1'b0;
      send(0, 4'h1); send(0, 4'h2); send(0, 4'h4); send(0, 4'h8);
      chk("t1b_result", outs(), pk(2'b01, 2'b00, 1, 1, 1, 0, 0));
      tick();
      chk("t1b_hold", outs(), pk(2'b00, 2'b00, 0, 0, 1, 0, 0));

      // Words 7,0,<3-cycle gap>,0,0 -> parity 1
      tick();
      chk("t2_grant", outs(), pk(2'b01, 2'b01, 1, 0, 1, 0, 0));
      send(0, 4'h7); send(0, 4'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_gap", outs(), pk(2'b01, 2'b01, 1, 0, 1, 0, 0));
      end
      send(0, 4'h0);
      chk("t2_word3", outs(), pk(2'b01, 2'b01, 1, 0, 1, 0, 0));
      send(0, 4'h0);
      chk("t2_result", outs(), pk(2'b01, 2'b00, 1, 1, 1, 0, 0));
      tick();
      req = 2'b00;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;

      // Both requesting: 0 first, requester 1 toggles valid with F meanwhile
      req = 2'b11;
      in_valid[1] = 1'b1; in_data1 = 4'hF;
      tick();
      chk("t3_grant0", outs(), pk(2'b01, 2'b01, 1, 0, 0, 0, 0));
      send(0, 4'h3);
      in_valid[1] = 1'b0;
      send(0, 4'h1);
      in_valid[1] = 1'b1;
      send(0, 4'h0);
      chk("t4_ready1_low", outs(), pk(2'b01, 2'b01, 1, 0, 0, 0, 0));
      send(0, 4'h0);
      chk("t3_res0", outs(), pk(2'b01, 2'b00, 1, 1, 1, 0, 0));
      in_valid[1] = 1'b0;
      tick();
      chk("t3_gap", outs(), pk(2'b00, 2'b00, 0, 0, 1, 0, 0));
      tick();
      chk("t3_grant1", outs(), pk(2'b10, 2'b10, 1, 0, 1, 0, 0));
      send(1, 4'h1); send(1, 4'h1); send(1, 4'h0); send(1, 4'h0);
      chk("t3_res1", outs(), pk(2'b10, 2'b00, 1, 1, 0, 1, 0));
      tick();
      chk("t3_idle", outs(), pk(2'b00, 2'b00, 0, 0, 0, 1, 0));
      tick();
      chk("t3_grant0_again", outs(), pk(2'b01, 2'b01, 1, 0, 0, 1, 0));

      // Requester 0 drops req after 2 words; pending requester 1 follows
      send(0, 4'h1); send(0, 4'h0);
      req = 2'b10;
      tick();
      chk("t5_abort", outs(), pk(2'b00, 2'b00, 0, 0, 0, 1, 1));
      tick();
      chk("t5_grant1", outs(), pk(2'b10, 2'b10, 1, 0, 0, 1, 0));
      send(1, 4'h8); send(1, 4'h0); send(1, 4'h0); send(1, 4'h0);
      chk("t5_res1", outs(), pk(2'b10, 2'b00, 1, 1, 1, 1, 0));
      req = 2'b00;
      tick();
      chk("t5_idle", outs(), pk(2'b00, 2'b00, 0, 0, 1, 1, 0));

      // Asynchronous reset between edges in the middle of a frame
      req = 2'b01;
      tick();
      chk("t6_grant", outs(), pk(2'b01, 2'b01, 1, 0, 1, 1, 0));
      send(0, 4'h1); send(0, 4'h0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_rst", outs(), pk(2'b00, 2'b00, 0, 0, 0, 0, 0));
      #1;
      rst_n = 1'b1;
      tick();
      chk("t6_regrant", outs(), pk(2'b01, 2'b01, 1, 0, 0, 0, 0));
      send(0, 4'h2); send(0, 4'h0); send(0, 4'h0);
      chk("t6_no_early_end", outs(), pk(2'b01, 2'b01, 1, 0, 0, 0, 0));
      send(0, 4'h0);
      chk("t6_res", outs(), pk(2'b01, 2'b00, 1, 1, 1, 0, 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/parity_frame_arbiter.md
Name: parity_frame_arbiter

Overview:
- Shares one serial parity engine between two requesters on the DE-board lab design.
- Each requester submits a frame of FRAME_LEN nibbles over a valid/ready handshake. The block grants requesters round-robin, XOR-accumulates every bit of the frame, and returns one even/odd parity bit tagged with the requester ID.
- Sits between switch/key-driven stimulus logic and the LEDR result display.

Parameters:
DATA_W, 4, width of each frame word in bits
FRAME_LEN, 4, words per frame (2..16)
CNT_W, 4, word-counter width, must satisfy 2**CNT_W >= FRAME_LEN

Ports:
CLOCK_50  input  1  system clock; all state updates on rising edge
RESET_N  input  1  asynchronous active-low reset
req  input  2  per-requester frame request, held high for the whole frame
in_valid  input  2  per-requester word valid
in_data0  input  DATA_W  requester 0 word
in_data1  input  DATA_W  requester 1 word
cfg_odd  input  1  0 = even parity, 1 = odd parity; sampled at grant
in_ready  output  2  per-requester word accept, one-hot or zero
gnt  output  2  registered one-hot grant, zero when idle
busy  output  1  high in any state except IDLE
res_valid  output  1  one-cycle pulse: parity result available
res_parity  output  1  parity result, held until the next res_valid
res_id  output  1  requester that owns res_parity
frame_abort  output  1  one-cycle pulse: frame dropped

Behaviour:
- Reset (RESET_N low, asynchronous): state = IDLE; gnt, in_ready, busy, res_valid, res_parity, res_id and frame_abort all 0; acc = 0; cnt = 0; rr_ptr = 0 (requester 0 favoured).
- States: IDLE, ACCUM, RESULT.
- IDLE:
  - If req == 2'b00, stay in IDLE.
  - Otherwise choose a winner. With a single request, that requester wins. With both requesting, the rr_ptr requester wins.
  - Next cycle: gnt = onehot(winner), odd_lat = cfg_odd, acc = 0, cnt = 0, state = ACCUM. Latency from req to gnt is 1 cycle.
- ACCUM:
  - in_ready[id] = 1 combinationally from state and grant; in_ready of the other requester = 0.
  - A word transfers when in_valid[id] and in_ready[id] are both high. Then acc <= acc ^ (XOR-reduce of the word) and cnt <= cnt + 1.
  - in_valid low stalls the frame; acc and cnt hold. Gaps of any length are legal.
  - The non-granted requester's in_valid and data are ignored.
  - A transfer with cnt == FRAME_LEN-1 moves the block to RESULT.
  - req[id] low in ACCUM, with or without a simultaneous transfer, is an abort. frame_abort pulses for 1 cycle, acc and cnt clear, rr_ptr <= ~id, state = IDLE, and no res_valid is issued.
- RESULT (1 cycle):
  - res_valid = 1, res_parity = acc ^ odd_lat, res_id = id. Latency from the last-word transfer to res_valid is 1 cycle.
  - rr_ptr <= ~id, gnt = 0, state = IDLE.
  - A requester holding req re-arbitrates in IDLE, so the minimum gap between frames is 1 IDLE cycle.
- cfg_odd changes mid-frame have no effect, because odd_lat is captured at grant.
- cnt never wraps: ACCUM exits at FRAME_LEN words.
- res_parity and res_id hold their last values between pulses.
- No combinational path from inputs to gnt, res_* or frame_abort.

Decomposition:
- Shared package parity_pkg:
  - State encoding constants ST_IDLE, ST_ACCUM, ST_RESULT (2 bits).
  - Defaults for DATA_W and FRAME_LEN.
  - Requester-ID width constant (1).
- One natural sub-module: parity_accum, which holds acc and cnt.
  - Inputs: clear, enable, word.
  - Outputs: acc, last (cnt == FRAME_LEN-1).
  - The top level holds the FSM, round-robin pointer and muxing.

Test Plan:
- Reset then req = 01, cfg_odd = 0, words 1, 2, 4, 8 on consecutive cycles -> gnt = 01 one cycle after req; res_valid pulses one cycle after the 4th transfer with res_parity = 0, res_id = 0; cfg_odd = 1 on the same frame -> res_parity = 1.
- req = 01, words 7, 0, 0, 0 with in_valid low for 3 cycles between words 2 and 3 -> cnt holds during the gap; res_parity = 1; total frame length 7 cycles of ACCUM.
- Both req high from reset -> requester 0 served first; requester 1 granted in the next arbitration (after 1 IDLE cycle), with res_id = 0 then 1; with both req still held, the third grant goes back to requester 0.
- During requester 0's frame, requester 1 toggles in_valid with data F -> in_ready[1] stays 0 and the result is unaffected.
- req[0] dropped after 2 words -> frame_abort pulses once, no res_valid, busy = 0 next cycle; a pending req[1] is granted next.
- RESET_N asserted mid-frame, asynchronously between clock edges -> all outputs 0 immediately; after release, a new frame from requester 0 gives a correct result with no leftover accumulator state.
